// File: rtl/ghost_mode_seq_pkg.sv
// rtl/ghost_mode_seq_pkg.sv - shared types and constants for the ghost mode sequencer
package ghost_mode_pkg;

    localparam int CNT_W     = 8;
    localparam int PHASE_CNT = 8;
    localparam int PHASE_W   = $clog2(PHASE_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCATTER = 2'b01,
        CHASE   = 2'b10,
        FRIGHT  = 2'b11
    } ghost_mode_t;

endpackage

// File: rtl/ghost_mode_seq_if.sv
// rtl/ghost_mode_seq_if.sv - game-event inputs and mode outputs of the ghost mode sequencer
interface ghost_mode_seq_if;
    import ghost_mode_pkg::*;

    logic               game_tick;
    logic               level_start;
    logic               power_pellet;
    logic               pause;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] phase;
    logic               reverse;
    logic               flash;

    // Game logic side: raises events, reads the mode
    modport master (
        output game_tick, level_start, power_pellet, pause,
        input  mode, phase, reverse, flash
    );

    // Sequencer side
    modport slave (
        input  game_tick, level_start, power_pellet, pause,
        output mode, phase, reverse, flash
    );
endinterface

// File: rtl/ghost_mode_seq_phase_table.sv
// rtl/ghost_mode_seq_phase_table.sv - phase number to duration and scatter/chase lookup
module ghost_phase_table
    import ghost_mode_pkg::*;
#(
    parameter int SCAT_LONG  = 14,
    parameter int SCAT_SHORT = 10,
    parameter int CHASE_LEN  = 40
) (
    input  logic [PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]   dur,
    output logic               is_scatter
);

    localparam logic [CNT_W-1:0] SCAT_LONG_W  = CNT_W'(SCAT_LONG);
    localparam logic [CNT_W-1:0] SCAT_SHORT_W = CNT_W'(SCAT_SHORT);
    localparam logic [CNT_W-1:0] CHASE_LEN_W  = CNT_W'(CHASE_LEN);

    // Even phases scatter, odd phases chase; the terminal phase has no duration
    always_comb begin
        is_scatter = ~phase[0];
        case (phase)
            3'd0, 3'd2:       dur = SCAT_LONG_W;
            3'd4, 3'd6:       dur = SCAT_SHORT_W;
            3'd1, 3'd3, 3'd5: dur = CHASE_LEN_W;
            default:          dur = '0;
        endcase
    end

endmodule

// File: rtl/ghost_mode_seq.sv
// rtl/ghost_mode_seq.sv - scatter/chase/frightened mode sequencer; GHOST_FLASH_WARN_EN enables flash
module ghost_mode_seq
    import ghost_mode_pkg::*;
#(
    parameter int SCAT_LONG  = 14,
    parameter int SCAT_SHORT = 10,
    parameter int CHASE_LEN  = 40,
    parameter int FRIGHT_LEN = 12,
    parameter int FLASH_LEN  = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    ghost_mode_seq_if.slave    bus
);

    localparam logic [CNT_W-1:0]   SCAT_LONG_W  = CNT_W'(SCAT_LONG);
    localparam logic [CNT_W-1:0]   FRIGHT_W     = CNT_W'(FRIGHT_LEN);
    localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(PHASE_CNT - 1);

    ghost_mode_t        state_q, state_d;
    logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0]   fright_cnt_q, fright_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               reverse_q, reverse_d;
    logic               tick_eff;
    logic [PHASE_W-1:0] tbl_phase;
    logic [CNT_W-1:0]   tbl_dur;
    logic               tbl_scatter;

    // While frightened we only need the current phase's flavour to resume;
    // otherwise the lookup is for the phase we would advance into.
    assign tbl_phase = (state_q == FRIGHT) ? phase_q : phase_q + PHASE_W'(1);

    ghost_phase_table #(
        .SCAT_LONG  (SCAT_LONG),
        .SCAT_SHORT (SCAT_SHORT),
        .CHASE_LEN  (CHASE_LEN)
    ) u_table (
        .phase      (tbl_phase),
        .dur        (tbl_dur),
        .is_scatter (tbl_scatter)
    );

    assign tick_eff = bus.game_tick & ~bus.pause;

    // Next-state logic: level_start beats power_pellet beats tick_eff
    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        fright_cnt_d = fright_cnt_q;
        phase_d      = phase_q;
        reverse_d    = 1'b0;
        if (bus.level_start) begin
            state_d      = SCATTER;
            phase_d      = '0;
            phase_cnt_d  = SCAT_LONG_W;
            fright_cnt_d = '0;
        end else begin
            case (state_q)
                SCATTER, CHASE: begin
                    if (bus.power_pellet) begin
                        // Any simultaneous tick is dropped
                        reverse_d = 1'b1;
                        if (FRIGHT_W != '0) begin
                            state_d      = FRIGHT;
                            fright_cnt_d = FRIGHT_W;
                        end
                    end else if (tick_eff && phase_q != LAST_PHASE) begin
                        if (phase_cnt_q == CNT_W'(1)) begin
                            phase_d     = phase_q + PHASE_W'(1);
                            phase_cnt_d = tbl_dur;
                            state_d     = tbl_scatter ? SCATTER : CHASE;
                            reverse_d   = 1'b1;
                        end else begin
                            phase_cnt_d = phase_cnt_q - CNT_W'(1);
                        end
                    end
                end
                FRIGHT: begin
                    if (bus.power_pellet) begin
                        fright_cnt_d = FRIGHT_W;
                    end else if (tick_eff) begin
                        fright_cnt_d = fright_cnt_q - CNT_W'(1);
                        if (fright_cnt_q == CNT_W'(1)) begin
                            state_d = tbl_scatter ? SCATTER : CHASE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            fright_cnt_q <= '0;
            phase_q      <= '0;
            reverse_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            fright_cnt_q <= fright_cnt_d;
            phase_q      <= phase_d;
            reverse_q    <= reverse_d;
        end
    end

`ifdef GHOST_FLASH_WARN_EN
    localparam logic [CNT_W-1:0] FLASH_W = CNT_W'(FLASH_LEN);

    logic flash_q, flash_d;

    // Warn during the last frightened ticks; computed from next state so it lines up with mode
    always_comb begin
        flash_d = (state_d == FRIGHT) && (fright_cnt_d <= FLASH_W);
    end

    // Flash register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
        end
    end

    assign bus.flash = flash_q;
`else
    assign bus.flash = 1'b0;
`endif

    assign bus.mode    = state_q;
    assign bus.phase   = phase_q;
    assign bus.reverse = reverse_q;

endmodule

// File: tb/tb_ghost_mode_seq.sv
// tb/tb_ghost_mode_seq.sv - directed self-checking bench for ghost_mode_seq
module tb_ghost_mode_seq;
    import ghost_mode_pkg::*;

`ifdef GHOST_FLASH_WARN_EN
    localparam logic FLASH_ON = 1'b1;
`else
    localparam logic FLASH_ON = 1'b0;
`endif

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    ghost_mode_seq_if bus ();

    ghost_mode_seq dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.game_tick = 1'b1;
            cycle();
            bus.game_tick = 1'b0;
        end
    endtask

    task automatic pellet(input logic with_tick);
        bus.power_pellet = 1'b1;
        bus.game_tick    = with_tick;
        cycle();
        bus.power_pellet = 1'b0;
        bus.game_tick    = 1'b0;
    endtask

    task automatic test_reset();
        bus.game_tick = 0; bus.level_start = 0; bus.power_pellet = 0; bus.pause = 0;
        Reset = 1'b1;
        cycle(); cycle();
        Reset = 1'b0;
        total++; if (bus.mode !== 2'b00) begin bad++; $display("FAIL reset_mode: got %b want 00", bus.mode); end
        total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
        total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL reset_reverse: got %b want 0", bus.reverse); end
        total++; if (bus.flash !== 1'b0) begin bad++; $display("FAIL reset_flash: got %b want 0", bus.flash); end
    endtask

    task automatic test_idle();
        tick(3);
        pellet(1'b0);
        tick(2);
        total++; if (bus.mode !== 2'b00 || bus.phase !== 3'd0 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL idle_ignore: mode=%b phase=%0d rev=%b want 00/0/0", bus.mode, bus.phase, bus.reverse); end
    endtask

    task automatic test_phase1();
        bus.level_start = 1'b1; cycle(); bus.level_start = 1'b0;
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd0 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL start: mode=%b phase=%0d rev=%b want 01/0/0", bus.mode, bus.phase, bus.reverse); end
        tick(13);
        total++; if (bus.mode !== 2'b01) begin bad++; $display("FAIL tick13_mode: got %b want 01", bus.mode); end
        tick(1);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd1 || bus.reverse !== 1'b1)
            begin bad++; $display("FAIL tick14: mode=%b phase=%0d rev=%b want 10/1/1", bus.mode, bus.phase, bus.reverse); end
        cycle();
        total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL tick14_rev_width: got %b want 0", bus.reverse); end
    endtask

    task automatic test_fright_round_trip();
        tick(5);
        pellet(1'b0);
        total++; if (bus.mode !== 2'b11 || bus.reverse !== 1'b1 || bus.phase !== 3'd1)
            begin bad++; $display("FAIL fright_enter: mode=%b rev=%b phase=%0d want 11/1/1", bus.mode, bus.reverse, bus.phase); end
        cycle();
        total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL fright_rev_width: got %b want 0", bus.reverse); end
        tick(7);
        total++; if (bus.flash !== 1'b0) begin bad++; $display("FAIL flash_early: got %b want 0", bus.flash); end
        tick(1);
        total++; if (bus.flash !== FLASH_ON) begin bad++; $display("FAIL flash_on8: got %b want %b", bus.flash, FLASH_ON); end
        tick(3);
        total++; if (bus.mode !== 2'b11 || bus.flash !== FLASH_ON)
            begin bad++; $display("FAIL fright_tick11: mode=%b flash=%b want 11/%b", bus.mode, bus.flash, FLASH_ON); end
        tick(1);
        total++; if (bus.mode !== 2'b10 || bus.reverse !== 1'b0 || bus.flash !== 1'b0)
            begin bad++; $display("FAIL fright_exit: mode=%b rev=%b flash=%b want 10/0/0", bus.mode, bus.reverse, bus.flash); end
        tick(34);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd1)
            begin bad++; $display("FAIL chase_resume34: mode=%b phase=%0d want 10/1", bus.mode, bus.phase); end
        tick(1);
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd2 || bus.reverse !== 1'b1)
            begin bad++; $display("FAIL phase2: mode=%b phase=%0d rev=%b want 01/2/1", bus.mode, bus.phase, bus.reverse); end
    endtask

    task automatic test_simultaneous();
        tick(3);
        pellet(1'b1);
        total++; if (bus.mode !== 2'b11 || bus.reverse !== 1'b1)
            begin bad++; $display("FAIL sim_pellet_tick: mode=%b rev=%b want 11/1", bus.mode, bus.reverse); end
        tick(12);
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd2)
            begin bad++; $display("FAIL sim_back_scatter: mode=%b phase=%0d want 01/2", bus.mode, bus.phase); end
        tick(10);
        total++; if (bus.mode !== 2'b01) begin bad++; $display("FAIL sim_cnt_kept: mode=%b want 01", bus.mode); end
        tick(1);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd3)
            begin bad++; $display("FAIL sim_phase3: mode=%b phase=%0d want 10/3", bus.mode, bus.phase); end
        pellet(1'b0);
        tick(11);
        pellet(1'b1);
        total++; if (bus.mode !== 2'b11 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL reload_at_one: mode=%b rev=%b want 11/0", bus.mode, bus.reverse); end
        tick(11);
        total++; if (bus.mode !== 2'b11) begin bad++; $display("FAIL reload_len11: mode=%b want 11", bus.mode); end
        tick(1);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd3)
            begin bad++; $display("FAIL reload_exit: mode=%b phase=%0d want 10/3", bus.mode, bus.phase); end
    endtask

    task automatic test_pause();
        bus.pause = 1'b1;
        tick(20);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd3 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL pause_hold: mode=%b phase=%0d rev=%b want 10/3/0", bus.mode, bus.phase, bus.reverse); end
        pellet(1'b0);
        total++; if (bus.mode !== 2'b11 || bus.reverse !== 1'b1)
            begin bad++; $display("FAIL pause_pellet: mode=%b rev=%b want 11/1", bus.mode, bus.reverse); end
        tick(20);
        total++; if (bus.mode !== 2'b11) begin bad++; $display("FAIL pause_fright_hold: mode=%b want 11", bus.mode); end
        bus.pause = 1'b0;
        tick(12);
        total++; if (bus.mode !== 2'b10) begin bad++; $display("FAIL pause_fright_exit: mode=%b want 10", bus.mode); end
        tick(39);
        total++; if (bus.phase !== 3'd3) begin bad++; $display("FAIL pause_cnt_frozen: phase=%0d want 3", bus.phase); end
        tick(1);
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd4)
            begin bad++; $display("FAIL phase4: mode=%b phase=%0d want 01/4", bus.mode, bus.phase); end
    endtask

    task automatic test_terminal();
        tick(10);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd5)
            begin bad++; $display("FAIL phase5: mode=%b phase=%0d want 10/5", bus.mode, bus.phase); end
        tick(40);
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd6)
            begin bad++; $display("FAIL phase6: mode=%b phase=%0d want 01/6", bus.mode, bus.phase); end
        tick(10);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd7 || bus.reverse !== 1'b1)
            begin bad++; $display("FAIL phase7: mode=%b phase=%0d rev=%b want 10/7/1", bus.mode, bus.phase, bus.reverse); end
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd7 || bus.reverse !== 1'b0)
                begin bad++; $display("FAIL phase7_hold[%0d]: mode=%b phase=%0d rev=%b want 10/7/0", i, bus.mode, bus.phase, bus.reverse); end
        end
        pellet(1'b0);
        tick(12);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd7)
            begin bad++; $display("FAIL phase7_fright_back: mode=%b phase=%0d want 10/7", bus.mode, bus.phase); end
    endtask

    task automatic test_level_restart();
        bus.level_start = 1'b1; bus.power_pellet = 1'b1; bus.game_tick = 1'b1;
        cycle();
        bus.level_start = 1'b0; bus.power_pellet = 1'b0; bus.game_tick = 1'b0;
        total++; if (bus.mode !== 2'b01 || bus.phase !== 3'd0 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL restart: mode=%b phase=%0d rev=%b want 01/0/0", bus.mode, bus.phase, bus.reverse); end
        tick(13);
        total++; if (bus.mode !== 2'b01) begin bad++; $display("FAIL restart_tick13: mode=%b want 01", bus.mode); end
        tick(1);
        total++; if (bus.mode !== 2'b10 || bus.phase !== 3'd1)
            begin bad++; $display("FAIL restart_phase1: mode=%b phase=%0d want 10/1", bus.mode, bus.phase); end
    endtask

    task automatic test_reset_mid_fright();
        pellet(1'b0);
        tick(8);
        total++; if (bus.mode !== 2'b11 || bus.flash !== FLASH_ON)
            begin bad++; $display("FAIL pre_reset: mode=%b flash=%b want 11/%b", bus.mode, bus.flash, FLASH_ON); end
        Reset = 1'b1; bus.level_start = 1'b1; bus.power_pellet = 1'b1; bus.game_tick = 1'b1;
        cycle();
        Reset = 1'b0; bus.level_start = 1'b0; bus.power_pellet = 1'b0; bus.game_tick = 1'b0;
        total++; if (bus.mode !== 2'b00 || bus.phase !== 3'd0 || bus.reverse !== 1'b0 || bus.flash !== 1'b0)
            begin bad++; $display("FAIL reset_mid_fright: mode=%b phase=%0d rev=%b flash=%b want 00/0/0/0", bus.mode, bus.phase, bus.reverse, bus.flash); end
        pellet(1'b0);
        total++; if (bus.mode !== 2'b00 || bus.reverse !== 1'b0)
            begin bad++; $display("FAIL post_reset_idle: mode=%b rev=%b want 00/0", bus.mode, bus.reverse); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bus.game_tick = 0; bus.level_start = 0; bus.power_pellet = 0; bus.pause = 0;
        test_reset();
        test_idle();
        test_phase1();
        test_fright_round_trip();
        test_simultaneous();
        test_pause();
        test_terminal();
        test_level_restart();
        test_reset_mid_fright();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ghost_mode_seq.md
# ghost_mode_seq

Ghost behaviour-mode sequencer for the Pac-Man game logic. It sits directly downstream of the game-step clock divider and consumes its one-cycle `game_clk` strobe. Each strobe advances the classic scatter/chase phase schedule. Power-pellet events preempt the schedule with a timed frightened mode. The block drives the mode, reverse-direction and flash signals read by the ghost AI and sprite renderer.

## Interface
Parameters:
- `SCAT_LONG`, 14: scatter duration in game ticks for phases 0 and 2.
- `SCAT_SHORT`, 10: scatter duration in game ticks for phases 4 and 6.
- `CHASE_LEN`, 40: chase duration in game ticks for phases 1, 3 and 5.
- `FRIGHT_LEN`, 12: frightened duration in game ticks. A value of 0 disables frightened mode.
- `FLASH_LEN`, 4: number of final frightened ticks during which `flash` is asserted.

Ports:
- `Clk` in 1: 50 MHz system clock; the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `game_tick` in 1: one-cycle game-step strobe from the game clock divider.
- `level_start` in 1: one-cycle pulse that restarts the schedule.
- `power_pellet` in 1: one-cycle pulse when Pac-Man eats a power pellet.
- `pause` in 1: level-sensitive; masks `game_tick` while high.
- `mode` out 2: current mode; 00 IDLE, 01 SCATTER, 10 CHASE, 11 FRIGHT.
- `phase` out 3: current schedule phase, 0–7.
- `reverse` out 1: one-cycle pulse commanding all ghosts to reverse direction.
- `flash` out 1: frightened-ending warning.

## Operation
- The FSM has four states: IDLE, SCATTER, CHASE, FRIGHT.
- Registered state: `phase_cnt` (8 bits), `fright_cnt` (8 bits), `phase` (3 bits).
- Phase table:
  - Phase 0 = S `SCAT_LONG`, phase 1 = C `CHASE_LEN`, phase 2 = S `SCAT_LONG`, phase 3 = C `CHASE_LEN`.
  - Phase 4 = S `SCAT_SHORT`, phase 5 = C `CHASE_LEN`, phase 6 = S `SCAT_SHORT`.
  - Phase 7 = CHASE, indefinite; `phase_cnt` is never decremented in phase 7.
  - Even phases are scatter, odd phases are chase.
- Effective tick: `tick_eff = game_tick & ~pause`.
- Event priority, highest first: `Reset`, `level_start`, `power_pellet`, `tick_eff`.
- IDLE: ignores ticks and pellets. Leaves only on `level_start`.
- `level_start` from any state:
  - Go to SCATTER with `phase` = 0 and `phase_cnt` = `SCAT_LONG`.
  - Clear `fright_cnt`. `reverse` stays 0.
- SCATTER/CHASE on `tick_eff`:
  - If `phase_cnt` == 1 and `phase` < 7: increment `phase`, load the next phase duration, switch mode, pulse `reverse`.
  - Otherwise, if `phase` < 7: decrement `phase_cnt`.
- SCATTER/CHASE on `power_pellet`:
  - If `FRIGHT_LEN` > 0: go to FRIGHT with `fright_cnt` = `FRIGHT_LEN` and pulse `reverse`.
  - If `FRIGHT_LEN` == 0: pulse `reverse` only; state is unchanged.
  - A simultaneous tick is dropped; `phase_cnt` is not decremented.
- FRIGHT:
  - `phase_cnt` and `phase` are frozen.
  - `power_pellet` reloads `fright_cnt` = `FRIGHT_LEN`, with no `reverse` pulse. The reload wins over a simultaneous tick.
  - On `tick_eff` with `fright_cnt` == 1: return to SCATTER if `phase` is even, CHASE if odd. No `reverse` pulse.
  - On any other `tick_eff`: decrement `fright_cnt`.
- Arithmetic: all counters are unsigned 8-bit. Parameters are truncated to 8 bits. Counters never wrap, because the reload at count 1 prevents underflow.

## Timing
- Reset values: `mode` = 00, `phase` = 0, `reverse` = 0, `flash` = 0, all counters = 0.
- All outputs are registered. The response appears in the cycle after the triggering input cycle, giving 1-cycle latency.
- `reverse` is high for exactly one `Clk` cycle per qualifying event, never two cycles back-to-back from a single event.
- A `Reset` asserted mid-FRIGHT or mid-phase forces IDLE on the next edge, regardless of other inputs.
- `pause` held high freezes all counting. Pellets are still accepted while paused.

## Configuration
- Macro: `GHOST_FLASH_WARN_EN`.
- Defined: `flash` = 1 while `mode` == FRIGHT and `fright_cnt` <= `FLASH_LEN`. `flash` is registered with the other outputs.
- Undefined: `flash` is constant 0. The comparison logic is not compiled in.

## Structure
- Shared package `ghost_mode_pkg` holds:
  - the `ghost_mode_t` enum (IDLE/SCATTER/CHASE/FRIGHT with the encodings above);
  - the phase count constant, 8;
  - the 8-bit counter width constant.
- Sub-module `ghost_phase_table`: a combinational lookup from `phase` plus the duration parameters to duration and scatter/chase flag.
- Everything else lives in one FSM with a next-state `always_comb` and a register `always_ff`.

## Test plan
- Reset-to-phase-1: `Reset`, then `level_start`, then 14 ticks → after the 14th tick `mode` = 10, `phase` = 1, and `reverse` is high for exactly 1 cycle.
- Frightened round trip: in phase 1, apply 5 ticks, then `power_pellet` → FRIGHT with a `reverse` pulse. After 12 more ticks → CHASE with no `reverse` pulse. After 35 more ticks → SCATTER with `phase` = 2.
- Flash (macro defined): after a pellet, 8 ticks → `flash` = 1. On the 12th tick `flash` drops with the mode exit. With the macro undefined, `flash` stays 0 throughout.
- Simultaneous events:
  - `power_pellet` and `game_tick` in the same cycle in SCATTER → FRIGHT, and `phase_cnt` is unchanged afterwards.
  - A second pellet on the tick where `fright_cnt` == 1 → still FRIGHT, `fright_cnt` = 12.
- Pause and idle: 20 ticks with `pause` = 1 → no change. Ticks in IDLE → `mode` stays 00.
- Terminal phase and reset: drive through phase 7, then 1000 ticks → `mode` = 10, `phase` = 7 throughout. `Reset` mid-FRIGHT → all outputs 0 on the next cycle.
